// File: rtl/d_sram_axi_bridge_if.sv
// d_sram_axi_bridge_if: cache-side SRAM-like data port and single-beat AXI4 bus bundles
interface d_sram_if #(parameter int ADDR_W = 32);
  logic              en;
  logic [3:0]        wen;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              stall;
  modport master (output en, wen, addr, wdata, input rdata, stall);
  modport slave  (input en, wen, addr, wdata, output rdata, stall);
endinterface

interface d_axi_if #(parameter int ADDR_W = 32);
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic [3:0]        awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic              bready;
  modport master (
    output arid, araddr, arlen, arsize, arvalid, rready,
           awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rlast, rvalid, awready, wready, bvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arvalid, rready,
           awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rlast, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/d_sram_axi_bridge.sv
// d_sram_axi_bridge: turns the data-cache SRAM port into single-beat AXI4 reads/writes, one at a time
module d_sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1,
  parameter int         ADDR_W = 32
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  d_sram_if.slave sram,
  d_axi_if.master axi
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]        wen_q, wen_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wen_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wen_q     <= wen_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wen_d     = wen_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: if (sram.en) begin
        addr_d    = sram.wen == 4'b0 ? {sram.addr[ADDR_W-1:2], 2'b00} : sram.addr;
        wdata_d   = sram.wdata;
        wen_d     = sram.wen;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = sram.wen == 4'b0 ? RD_ADDR : WR;
      end
      RD_ADDR: state_d = axi.arready ? RD_DATA : RD_ADDR;
      RD_DATA: if (axi.rvalid) begin
        rdata_d = axi.rdata;
        state_d = DONE;
      end
      WR: begin
        // AW and W complete independently, possibly in the same cycle
        aw_done_d = aw_done_q | (axi.awvalid & axi.awready);
        w_done_d  = w_done_q | (axi.wvalid & axi.wready);
        state_d   = aw_done_d & w_done_d ? WR_RESP : WR;
      end
      WR_RESP: state_d = axi.bvalid ? DONE : WR_RESP;
      default: state_d = IDLE;
    endcase
  end
  assign sram.rdata  = rdata_q;
  assign sram.stall  = sram.en & (state_q != DONE);
  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arvalid = state_q == RD_ADDR;
  assign axi.rready  = state_q == RD_DATA;
  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = (wen_q == 4'b0011 || wen_q == 4'b1100) ? 3'd1 :
                       (wen_q != 4'b0 && (wen_q & (wen_q - 4'd1)) == 4'b0) ? 3'd0 : 3'd2;
  assign axi.awvalid = state_q == WR && !aw_done_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wen_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = state_q == WR && !w_done_q;
  assign axi.bready  = state_q == WR_RESP;
endmodule

// File: tb/tb_d_sram_axi_bridge.sv
// tb_d_sram_axi_bridge: randomized scoreboard bench with a memory-backed AXI slave and reference memory
module tb_d_sram_axi_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  d_sram_if #(.ADDR_W(32)) sram();
  d_axi_if  #(.ADDR_W(32)) axi();

  d_sram_axi_bridge #(.AXI_ID(4'd1), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sram(sram.slave), .axi(axi.master)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // reference model: a byte-addressed memory image plus the last load result
  logic [31:0] rmem [logic [31:0]];
  logic [31:0] last_rd;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : seed_word(a);
  endfunction

  function automatic logic [2:0] exp_size(input logic [3:0] w);
    if ($countones(w) == 1) return 3'd0;
    if (w == 4'b0011 || w == 4'b1100) return 3'd1;
    return 3'd2;
  endfunction

  typedef struct { logic [31:0] addr; logic [2:0] size; } a_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;
  a_t          ar_q[$], aw_q[$];
  w_t          w_q[$];
  logic [31:0] done_q[$];

  // AXI slave with its own memory image and per-channel ready/valid delays
  bit          rnd;
  int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
  logic [31:0] smem [logic [31:0]];
  bit          ar_arm, aw_arm, w_arm, r_pend, b_pend, aw_got, w_got;
  bit          ar_hs, r_hs, aw_hs, w_hs, b_hs;
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic [31:0] s_araddr, s_awaddr, s_wdata, r_word, s_word, s_wa;
  logic [3:0]  s_wstrb;

  function automatic int nd(input int d);
    return rnd ? int'($urandom_range(0, 3)) : d;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      {ar_arm, aw_arm, w_arm, r_pend, b_pend, aw_got, w_got} = '0;
      {ar_hs, r_hs, aw_hs, w_hs, b_hs} = '0;
      {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
      axi.arready = 0; axi.rvalid = 0; axi.rlast = 0; axi.rdata = 0;
      axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
    end else begin
      if (ar_hs) begin
        ar_arm = 0; r_pend = 1; r_cnt = nd(r_dly);
        r_word = smem.exists(s_araddr) ? smem[s_araddr] : seed_word(s_araddr);
      end
      if (r_hs) r_pend = 0;
      if (aw_hs) begin aw_arm = 0; aw_got = 1; end
      if (w_hs) begin w_arm = 0; w_got = 1; end
      if (aw_got && w_got) begin
        s_wa = {s_awaddr[31:2], 2'b00};
        s_word = smem.exists(s_wa) ? smem[s_wa] : seed_word(s_wa);
        for (int i = 0; i < 4; i++) if (s_wstrb[i]) s_word[8*i +: 8] = s_wdata[8*i +: 8];
        smem[s_wa] = s_word;
        aw_got = 0; w_got = 0; b_pend = 1; b_cnt = nd(b_dly);
      end
      if (b_hs) b_pend = 0;
      if (axi.arvalid && !ar_arm) begin ar_arm = 1; ar_cnt = nd(ar_dly); end
      if (axi.awvalid && !aw_arm) begin aw_arm = 1; aw_cnt = nd(aw_dly); end
      if (axi.wvalid && !w_arm) begin w_arm = 1; w_cnt = nd(w_dly); end
      axi.arready = axi.arvalid && ar_arm && ar_cnt == 0;
      axi.awready = axi.awvalid && aw_arm && aw_cnt == 0;
      axi.wready  = axi.wvalid && w_arm && w_cnt == 0;
      if (axi.arvalid && ar_cnt > 0) ar_cnt--;
      if (axi.awvalid && aw_cnt > 0) aw_cnt--;
      if (axi.wvalid && w_cnt > 0) w_cnt--;
      axi.rvalid = r_pend && r_cnt == 0;
      axi.rlast  = axi.rvalid;
      axi.rdata  = axi.rvalid ? r_word : $urandom;
      if (r_pend && r_cnt > 0) r_cnt--;
      axi.bvalid = b_pend && b_cnt == 0;
      if (b_pend && b_cnt > 0) b_cnt--;
      ar_hs = axi.arvalid && axi.arready;
      r_hs  = axi.rvalid && axi.rready;
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      b_hs  = axi.bvalid && axi.bready;
      if (ar_hs) s_araddr = axi.araddr;
      if (aw_hs) s_awaddr = axi.awaddr;
      if (w_hs) begin s_wdata = axi.wdata; s_wstrb = axi.wstrb; end
    end
  end

  // monitor: checks every handshake and completion against the scoreboard queues
  bit          pa, paw, pw;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  logic [3:0]  p_wstrb;
  a_t          ea;
  w_t          ew;
  logic [31:0] ed;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      pa = 0; paw = 0; pw = 0;
    end else begin
      if (pa) begin
        chk("arvalid_held", 32'(axi.arvalid), 1);
        chk("araddr_stable", axi.araddr, p_araddr);
      end
      if (paw) begin
        chk("awvalid_held", 32'(axi.awvalid), 1);
        chk("awaddr_stable", axi.awaddr, p_awaddr);
      end
      if (pw) begin
        chk("wvalid_held", 32'(axi.wvalid), 1);
        chk("wdata_stable", axi.wdata, p_wdata);
        chk("wstrb_stable", 32'(axi.wstrb), 32'(p_wstrb));
      end
      if (axi.arvalid && axi.arready) begin
        if (ar_q.size() == 0) bad("ar_unexpected");
        else begin
          ea = ar_q.pop_front();
          chk("araddr", axi.araddr, ea.addr);
          chk("arsize", 32'(axi.arsize), 32'(ea.size));
          chk("arlen", 32'(axi.arlen), 0);
          chk("arid", 32'(axi.arid), 1);
        end
      end
      if (axi.awvalid && axi.awready) begin
        if (aw_q.size() == 0) bad("aw_unexpected");
        else begin
          ea = aw_q.pop_front();
          chk("awaddr", axi.awaddr, ea.addr);
          chk("awsize", 32'(axi.awsize), 32'(ea.size));
          chk("awlen", 32'(axi.awlen), 0);
          chk("awid", 32'(axi.awid), 1);
        end
      end
      if (axi.wvalid && axi.wready) begin
        if (w_q.size() == 0) bad("w_unexpected");
        else begin
          ew = w_q.pop_front();
          chk("wdata", axi.wdata, ew.data);
          chk("wstrb", 32'(axi.wstrb), 32'(ew.strb));
          chk("wlast", 32'(axi.wlast), 1);
        end
      end
      if (sram.en && !sram.stall) begin
        if (done_q.size() == 0) bad("done_unexpected");
        else begin
          ed = done_q.pop_front();
          chk("done_rdata", sram.rdata, ed);
        end
      end
      pa = axi.arvalid && !axi.arready; p_araddr = axi.araddr;
      paw = axi.awvalid && !axi.awready; p_awaddr = axi.awaddr;
      pw = axi.wvalid && !axi.wready; p_wdata = axi.wdata; p_wstrb = axi.wstrb;
    end
  end

  // driver: presents one request, records expectations, waits for the stall to lift
  task automatic issue(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       output int cyc, output int awc, output int wc);
    logic [31:0] wa, cur;
    wa = {a[31:2], 2'b00};
    @(negedge clk);
    sram.en = 1; sram.wen = w; sram.addr = a; sram.wdata = d;
    if (w == 4'b0) begin
      ar_q.push_back('{wa, 3'd2});
      last_rd = ref_rd(wa);
    end else begin
      aw_q.push_back('{a, exp_size(w)});
      w_q.push_back('{d, w});
      cur = ref_rd(wa);
      for (int i = 0; i < 4; i++) if (w[i]) cur[8*i +: 8] = d[8*i +: 8];
      rmem[wa] = cur;
    end
    done_q.push_back(last_rd);
    cyc = 0; awc = 0; wc = 0;
    forever begin
      #1;
      if (!sram.stall) break;
      if (axi.awvalid) awc++;
      if (axi.wvalid) wc++;
      cyc++;
      if (cyc > 300) begin bad("request_timeout"); break; end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] wens [13] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 4'b0010, 4'b0100,
                            4'b1000, 4'b0011, 4'b1100, 4'b0101, 4'b0111, 4'b1110};

  initial begin
    int c, awc, wc, n;
    logic [3:0] w;
    logic [31:0] a;
    sram.en = 0; sram.wen = 0; sram.addr = 0; sram.wdata = 0;
    rnd = 0; ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0; last_rd = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_arvalid", 32'(axi.arvalid), 0);
    chk("rst_awvalid", 32'(axi.awvalid), 0);
    chk("rst_wvalid", 32'(axi.wvalid), 0);
    chk("rst_rready", 32'(axi.rready), 0);
    chk("rst_bready", 32'(axi.bready), 0);
    chk("rst_rdata", sram.rdata, 0);
    chk("rst_araddr", axi.araddr, 0);
    chk("rst_stall", 32'(sram.stall), 0);
    @(negedge clk) rst_n = 1;

    rmem[32'h1FC0_0004] = 32'hDEAD_BEEF;
    smem[32'h1FC0_0004] = 32'hDEAD_BEEF;
    issue(4'b0000, 32'h1FC0_0006, 32'h0, c, awc, wc);
    chk("rd_zero_wait_stall", 32'(c), 3);
    @(negedge clk) sram.en = 0;
    #1 chk("rd_rdata_held", sram.rdata, 32'hDEAD_BEEF);

    aw_dly = 3; w_dly = 0; b_dly = 2;
    issue(4'b0100, 32'h8000_0002, 32'h00AB_0000, c, awc, wc);
    chk("byte_awvalid_cycles", 32'(awc), 4);
    chk("byte_wvalid_cycles", 32'(wc), 1);
    chk("byte_stall", 32'(c), 8);

    aw_dly = 0; b_dly = 0;
    issue(4'b1111, 32'h8000_0010, 32'h1357_9BDF, c, awc, wc);
    chk("sim_awvalid_cycles", 32'(awc), 1);
    chk("sim_wvalid_cycles", 32'(wc), 1);
    chk("sim_stall", 32'(c), 3);

    ar_dly = 5; r_dly = 4;
    issue(4'b0000, 32'h8000_0001, 32'h0, c, awc, wc);
    chk("slow_rd_stall", 32'(c), 12);
    ar_dly = 0; r_dly = 0;

    issue(4'b0011, 32'h8000_0020, 32'hCAFE_F00D, c, awc, wc);
    issue(4'b0000, 32'h8000_0020, 32'h0, c, awc, wc);
    chk("b2b_load_stall", 32'(c), 3);

    r_dly = 6;
    @(negedge clk);
    sram.en = 1; sram.wen = 0; sram.addr = 32'h8000_0044;
    ar_q.push_back('{32'h8000_0044, 3'd2});
    done_q.push_back(ref_rd(32'h8000_0044));
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!axi.rready && n < 20);
    chk("rst_mid_in_rd_data", 32'(axi.rready), 1);
    #1 rst_n = 0; sram.en = 0;
    #1;
    chk("rst_mid_rready", 32'(axi.rready), 0);
    chk("rst_mid_arvalid", 32'(axi.arvalid), 0);
    chk("rst_mid_stall", 32'(sram.stall), 0);
    chk("rst_mid_rdata", sram.rdata, 0);
    ar_q.delete(); aw_q.delete(); w_q.delete(); done_q.delete();
    last_rd = 0;
    repeat (2) @(negedge clk);
    rst_n = 1; r_dly = 0;
    issue(4'b0000, 32'h8000_0044, 32'h0, c, awc, wc);
    chk("post_rst_rd_stall", 32'(c), 3);

    rnd = 1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) begin @(negedge clk); sram.en = 0; end
      w = wens[$urandom_range(0, 12)];
      a = 32'h8000_0000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      issue(w, a, $urandom, c, awc, wc);
    end
    @(negedge clk) sram.en = 0;
    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(ar_q.size() + aw_q.size() + w_q.size() + done_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/d_sram_axi_bridge.md
Name: d_sram_axi_bridge

Overview:
- Sits directly downstream of the data-side cache stage.
- Converts its SRAM-like data port (enable, byte write-enables, address, write data, read data) into single-beat AXI4 read and write transactions.
- Stalls the pipeline while a transaction is in flight and returns load data registered.
- Handles one outstanding request at a time. No caching and no buffering beyond the current request.

Parameters:
- AXI_ID, 4'd1, value driven on arid and awid.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- data_sram_en  in  1  request valid from cache stage; held stable while stall=1.
- data_sram_wen  in  4  byte write strobes; 0 = read.
- data_sram_addr  in  ADDR_W  byte address.
- data_sram_wdata  in  32  store data, already lane-aligned.
- data_sram_rdata  out  32  load data, registered.
- stall  out  1  pipeline hold request.
- arid/araddr/arlen/arsize/arvalid  out  4/ADDR_W/8/3/1  AXI read address.
- arready  in  1
- rdata/rlast/rvalid  in  32/1/1
- rready  out  1
- awid/awaddr/awlen/awsize/awvalid  out  4/ADDR_W/8/3/1  AXI write address.
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1
- wready  in  1
- bvalid  in  1
- bready  out  1

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All valid/ready outputs 0; data_sram_rdata=0.
  - Address and data registers 0.
  - Any in-flight AXI transaction is abandoned.
- stall = data_sram_en & (state != DONE), combinational.
- **IDLE**:
  - en=1 & wen=0: latch addr with [1:0] forced to 0; go to RD_ADDR.
  - en=1 & wen!=0: latch addr, wdata, wen; go to WR.
  - en=0: stay in IDLE.
- **RD_ADDR**:
  - arvalid=1, arlen=0, arsize=3'b010.
  - On arready, go to RD_DATA.
- **RD_DATA**:
  - rready=1.
  - On rvalid: capture rdata into data_sram_rdata; go to DONE.
  - rlast is ignored (single beat).
- **WR**:
  - awvalid and wvalid both asserted on entry, each independent.
  - Each drops after its own handshake; aw_done and w_done flags track completion.
  - Both handshakes may complete in the same cycle, in either order, or simultaneously.
  - Once both are done, go to WR_RESP.
  - wlast=1, awlen=0.
  - awaddr is the latched address with [1:0] unchanged; wstrb = latched wen.
  - awsize is derived from wen: 4'b1111→2; 4'b0011/4'b1100→1; single bit set→0; any other pattern→2.
- **WR_RESP**:
  - bready=1.
  - On bvalid, go to DONE. bresp is not checked.
- **DONE**:
  - stall=0 for exactly one cycle; the pipeline advances.
  - Always go to IDLE next.
  - data_sram_rdata holds its value until the next read capture; writes leave it unchanged.
- Valid signals and their payloads must remain stable until handshake (AXI rule).
- Minimum latency with slaves ready immediately:
  - Read: request seen at cycle 0 (IDLE); arvalid cycle 1; r handshake cycle 2; DONE cycle 3.
  - Write: same, 4 cycles with stall high for 3.
- A new request presented in the cycle after DONE is accepted from IDLE normally. There is no back-to-back bypass.
- If en drops mid-transaction (illegal), the transaction still completes; stall follows en.

Test Plan:
- Read, zero-wait slave:
  - Stimulus: en=1, wen=0, addr=0x1FC0_0006; slave returns rdata=0xDEADBEEF.
  - Response: araddr=0x1FC0_0004, arsize=2, arlen=0; stall high 3 cycles; data_sram_rdata=0xDEADBEEF at DONE.
- Byte store:
  - Stimulus: wen=4'b0100, addr=0x8000_0002, wdata=0x00AB_0000; awready delayed 3 cycles, wready immediate.
  - Response: awsize=0, awaddr=0x8000_0002, wstrb=0100; wvalid drops after 1 cycle; awvalid held 4 cycles; DONE only after bvalid.
- Simultaneous handshakes:
  - Stimulus: wen=1111 store with awready=wready=1 in the same cycle.
  - Response: both valids drop together; WR_RESP next cycle.
- Read with slow slave:
  - Stimulus: arready delayed 5 cycles, rvalid delayed 4 cycles.
  - Response: araddr and arvalid stable throughout; rdata captured only on rvalid.
- Back-to-back requests:
  - Stimulus: store then load issued consecutively.
  - Response: the load is taken from IDLE one cycle after DONE; the previous rdata is unchanged by the store.
- Async reset mid-operation:
  - Stimulus: rst=0 asserted during RD_DATA, between clock edges.
  - Response: rready, arvalid and stall go to 0 immediately; data_sram_rdata=0; after release, IDLE accepts a new request.
